// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready
// on both sides, all outputs registered. Divide-by-zero short-circuits to DONE.
`timescale 1ns/1ps
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(DW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid/operands are ignored while ready is low.

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [VW-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [VW:0]   trial;
  logic          trial_ge;
  logic [VW-1:0] r_sub;
  logic [VW-1:0] step_r;
  logic [DW-1:0] step_q;

  // Partial remainder always stays below the divisor, so T-D fits in VW bits
  // whenever the subtraction is taken; the modulo VW-bit difference is exact.
  always_comb begin
    trial    = {r_q, q_q[DW-1]};
    trial_ge = (trial >= {1'b0, d_q});
    r_sub    = trial[VW-1:0] - d_q;
    step_r   = trial_ge ? r_sub : trial[VW-1:0];
    step_q   = {q_q[DW-2:0], trial_ge};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          q_d = dividend;
          d_d = divisor;
          r_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(DW - 1);
          end
        end
      end
      CALC: begin
        r_d = step_r;
        q_d = step_q;
        if (cnt_q == '0) begin
          quot_d  = step_q;
          rem_d   = step_r;
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive-operand bench for seq_restoring_divider (DW=8, VW=4).
`timescale 1ns/1ps
module tb_seq_restoring_divider;

  localparam logic [1:0] S_IDLE = 2'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {div_by_zero, quotient, remainder}
  logic [12:0] exp_q[$];

  seq_restoring_divider #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [7:0] dd, input logic [3:0] dv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL start_timeout in_ready=%b required 1", in_ready);
      errors++;
    end
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 30);
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%b exp=0", in_ready); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (quotient !== 8'd0) begin $display("FAIL reset_quotient got=%0d exp=0", quotient); errors++; end
    checks++; if (remainder !== 4'd0) begin $display("FAIL reset_remainder got=%0d exp=0", remainder); errors++; end
    checks++; if (div_by_zero !== 1'b0) begin $display("FAIL reset_dbz got=%b exp=0", div_by_zero); errors++; end
    checks++; if (dbg_state !== S_IDLE) begin $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); errors++; end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL release_in_ready_early got=%b exp=0", in_ready); errors++; end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin $display("FAIL release_in_ready got=%b exp=1", in_ready); errors++; end
  endtask

  task automatic test_basic();
    int lat;
    start_op(8'd200, 4'd7);
    checks++; if (in_ready !== 1'b0) begin $display("FAIL basic_in_ready_drop got=%b exp=0", in_ready); errors++; end
    wait_result(lat);
    checks++; if (lat !== 9) begin $display("FAIL basic_latency got=%0d exp=9", lat); errors++; end
    checks++; if (quotient !== 8'd28) begin $display("FAIL basic_quotient got=%0d exp=28", quotient); errors++; end
    checks++; if (remainder !== 4'd4) begin $display("FAIL basic_remainder got=%0d exp=4", remainder); errors++; end
    checks++; if (div_by_zero !== 1'b0) begin $display("FAIL basic_dbz got=%b exp=0", div_by_zero); errors++; end
    pop_result();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL basic_pop_out_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL basic_pop_in_ready got=%b exp=1", in_ready); errors++; end
  endtask

  task automatic test_vectors();
    // {dividend, divisor, quotient, remainder, dbz, latency}
    logic [7:0] v_dd[6]  = '{8'd255, 8'd13, 8'd0, 8'd5,   8'd100, 8'd1};
    logic [3:0] v_dv[6]  = '{4'd15,  4'd15, 4'd1, 4'd0,   4'd3,   4'd1};
    logic [7:0] v_q[6]   = '{8'd17,  8'd0,  8'd0, 8'd255, 8'd33,  8'd1};
    logic [3:0] v_r[6]   = '{4'd0,   4'd13, 4'd0, 4'd5,   4'd1,   4'd0};
    logic       v_z[6]   = '{1'b0,   1'b0,  1'b0, 1'b1,   1'b0,   1'b0};
    int         v_lat[6] = '{9,      9,     9,    1,      9,      9};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(v_dd[i], v_dv[i]);
      checks++; if (in_ready !== 1'b0) begin $display("FAIL vec%0d_in_ready_drop got=%b exp=0", i, in_ready); errors++; end
      wait_result(lat);
      checks++; if (lat !== v_lat[i]) begin $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, v_lat[i]); errors++; end
      checks++; if (quotient !== v_q[i]) begin $display("FAIL vec%0d_quotient got=%0d exp=%0d", i, quotient, v_q[i]); errors++; end
      checks++; if (remainder !== v_r[i]) begin $display("FAIL vec%0d_remainder got=%0d exp=%0d", i, remainder, v_r[i]); errors++; end
      checks++; if (div_by_zero !== v_z[i]) begin $display("FAIL vec%0d_dbz got=%b exp=%b", i, div_by_zero, v_z[i]); errors++; end
      pop_result();
      checks++; if (out_valid !== 1'b0) begin $display("FAIL vec%0d_pop_out_valid got=%b exp=0", i, out_valid); errors++; end
      checks++; if (in_ready !== 1'b1) begin $display("FAIL vec%0d_pop_in_ready got=%b exp=1", i, in_ready); errors++; end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'd77, 4'd9);
    wait_result(lat);
    checks++; if (lat !== 9) begin $display("FAIL bp_latency got=%0d exp=9", lat); errors++; end
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      dividend = 8'd3;
      divisor  = 4'd1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin $display("FAIL bp_hold%0d_out_valid got=%b exp=1", i, out_valid); errors++; end
      checks++; if (quotient !== 8'd8) begin $display("FAIL bp_hold%0d_quotient got=%0d exp=8", i, quotient); errors++; end
      checks++; if (remainder !== 4'd5) begin $display("FAIL bp_hold%0d_remainder got=%0d exp=5", i, remainder); errors++; end
      checks++; if (in_ready !== 1'b0) begin $display("FAIL bp_hold%0d_in_ready got=%b exp=0", i, in_ready); errors++; end
    end
    in_valid = 1'b0;
    pop_result();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_pop_out_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL bp_pop_in_ready got=%b exp=1", in_ready); errors++; end
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin $display("FAIL bp_idle_state got=%0d exp=%0d", dbg_state, S_IDLE); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_no_ghost got=%b exp=0", out_valid); errors++; end
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(8'd200, 4'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL areset_out_valid got=%b exp=0", out_valid); errors++; end
    checks++; if (quotient !== 8'd0) begin $display("FAIL areset_quotient got=%0d exp=0", quotient); errors++; end
    checks++; if (remainder !== 4'd0) begin $display("FAIL areset_remainder got=%0d exp=0", remainder); errors++; end
    checks++; if (in_ready !== 1'b0) begin $display("FAIL areset_in_ready got=%b exp=0", in_ready); errors++; end
    checks++; if (dbg_state !== S_IDLE) begin $display("FAIL areset_state got=%0d exp=%0d", dbg_state, S_IDLE); errors++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin $display("FAIL areset_discard got=%b exp=0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL areset_in_ready_after got=%b exp=1", in_ready); errors++; end
    start_op(8'd50, 4'd6);
    wait_result(lat);
    checks++; if (lat !== 9) begin $display("FAIL areset_next_latency got=%0d exp=9", lat); errors++; end
    checks++; if (quotient !== 8'd8) begin $display("FAIL areset_next_quotient got=%0d exp=8", quotient); errors++; end
    checks++; if (remainder !== 4'd2) begin $display("FAIL areset_next_remainder got=%0d exp=2", remainder); errors++; end
    checks++; if (div_by_zero !== 1'b0) begin $display("FAIL areset_next_dbz got=%b exp=0", div_by_zero); errors++; end
    pop_result();
  endtask

  task automatic test_regression();
    int lat;
    int results = 0;
    int exp_lat;
    logic [12:0] exp_v;
    logic [12:0] got_v;
    logic [7:0]  eq;
    logic [3:0]  er;
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        if (dv == 0) begin
          eq = 8'hFF;
          er = dd[3:0];
        end else begin
          eq = 8'(dd / dv);
          er = 4'(dd % dv);
        end
        exp_q.push_back({(dv == 0), eq, er});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_op(8'(dd), 4'(dv));
        out_ready = ($urandom_range(0, 1) == 1);
        wait_result(lat);
        exp_lat = (dv == 0) ? 1 : 9;
        checks++; if (lat !== exp_lat) begin $display("FAIL reg_latency %0d/%0d got=%0d exp=%0d", dd, dv, lat, exp_lat); errors++; end
        got_v = {div_by_zero, quotient, remainder};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
        results++;
        checks++; if (got_v !== exp_v) begin $display("FAIL reg_result %0d/%0d got=%h exp=%h", dd, dv, got_v, exp_v); errors++; end
        if (dv != 0) begin
          checks++;
          if ((int'(quotient) * dv + int'(remainder)) != dd || int'(remainder) >= dv) begin
            $display("FAIL reg_identity %0d/%0d q=%0d r=%0d", dd, dv, quotient, remainder);
            errors++;
          end
        end
        if (!out_ready) repeat ($urandom_range(0, 2)) @(negedge clk);
        pop_result();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reg_pop %0d/%0d out_valid got=%b exp=0", dd, dv, out_valid); errors++; end
      end
    end
    checks++; if (results !== 4096 || exp_q.size() !== 0) begin $display("FAIL reg_count got=%0d pending=%0d exp=4096 pending=0", results, exp_q.size()); errors++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_async_reset();
    test_regression();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
